ysyx_220066_clint_mh: RTL and testbench
=======================================

// Module: ysyx_220066_clint_mh
// PURPOSE
//  Multi-hart core-local interruptor; generalised successor of the single-hart timer block.
//  - Sits on the CPU data-memory path.
//  - Claims [BASE, BASE+0xC000) and forwards all other accesses to memory unchanged.
//  - Provides a shared 64-bit mtime with programmable prescaler.
//  - Provides per-hart mtimecmp and msip, with byte-masked writes.
//  - Registered 1-cycle read data with a valid strobe; mtip/msip interrupt outputs per hart.
// PARAMETERS
//  NHART         1              number of harts (1..16)
//  BASE          64'h2000000    base address of the CLINT window
//  TICK_DIV      1              mtime increments once every TICK_DIV clocks (>=1)
//  MTIMECMP_RST  64'h100        reset value of every mtimecmp
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst         in   1        asynchronous, active-low reset
//  addr        in   64       access address (byte address)
//  MemRd       in   1        read request this cycle
//  MemWr       in   1        write request this cycle
//  data        in   64       write data
//  wstrb       in   8        byte write enables for data
//  MemRd_real  out  1        MemRd && !hit, comb
//  MemWr_real  out  1        MemWr && !hit, comb
//  data_rd     out  64       read data, registered
//  rd_valid    out  1        data_rd valid this cycle, registered
//  error       out  1        previous access hit an unmapped or misaligned CLINT slot, registered
//  msip        out  NHART    software interrupt pending per hart
//  mtip        out  NHART    timer interrupt pending per hart, registered
// BEHAVIOUR
//  - Reset (rst==0): immediate, mid-transaction included.
//    - Cleared to 0: mtime, prescaler, msip, mtip, data_rd, rd_valid, error.
//    - mtimecmp[*] <= MTIMECMP_RST.
//  - Address decode (comb)
//    - hit = BASE <= addr < BASE+0xC000.
//    - off = addr - BASE, 16 bits.
//  - Register map
//    - msip[h]: off = 4*h, 32-bit slot. Only bit0 is stored; other bits read 0.
//    - mtimecmp[h]: off = 0x4000 + 8*h, 64-bit.
//    - mtime: off = 0xBFF8, 64-bit.
//    - Any other off, any hart index >= NHART, or addr[2:0] not naturally aligned to the slot: unmapped.
//  - Unmapped access: write ignored; read returns 0; error=1 on the next cycle.
//  - Read latency: MemRd && hit in cycle N -> rd_valid=1 and data_rd=value in cycle N+1.
//    - Outside such cycles, rd_valid=0 and data_rd holds its last value.
//    - msip read: zero-extended to 64 bits and placed in bits [31:0] when addr[2]==0, or bits [63:32] when addr[2]==1.
//  - error: registered each cycle as ((MemRd||MemWr) && hit && unmapped). Cleared the next cycle otherwise.
//  - Writes commit on the posedge ending the request cycle.
//    - Only bytes with wstrb set change.
//    - msip write: uses the byte lane selected by addr[2] (wstrb[0] or wstrb[4]).
//  - Prescaler: counts 0..TICK_DIV-1 and wraps; mtime += 1 on the wrap cycle.
//    - TICK_DIV==1 means mtime increments every clock.
//  - mtime wraps 2^64-1 -> 0 silently.
//  - Simultaneous MemWr to mtime and a tick: the written value wins, with no +1 that cycle, and the prescaler restarts at 0.
//  - MemRd && MemWr to the same slot in the same cycle: data_rd returns the pre-write value.
//  - mtip[h] <= (mtime >= mtimecmp[h]), unsigned, registered.
//    - Uses the mtime/mtimecmp values before this cycle's update, so mtip lags a write by 1 cycle.
//  - Non-hit accesses: CLINT state untouched (mtime still ticks); rd_valid=0; error=0.
// TESTING
//  - Release reset, TICK_DIV=1, no access:
//    - mtime reads 0x10 ten cycles after a read issued at mtime 0x06.
//    - mtip[0] rises the cycle after mtime reaches 0x100.
//  - NHART=2: write mtimecmp[1]=0x20 (wstrb 0xFF) -> mtip[1]=1 and mtip[0]=0 while 0x20 <= mtime < 0x100.
//  - Write msip[1] with addr=BASE+4 and data=64'h1_0000_0000:
//    - msip=2'b10.
//    - A read of BASE+4 returns data_rd=64'h1_0000_0000 with rd_valid=1 one cycle later.
//  - Write mtime=64'hFFFF_FFFF_FFFF_FFFF, wstrb=8'h0F:
//    - Only the low 32 bits change.
//    - Then write all ones with wstrb 0xFF -> mtime wraps to 0 one tick later.
//  - Read BASE+0x4010 with NHART=2 -> data_rd=0, error=1 next cycle; read addr 0x8000_0000 -> MemRd_real=1, rd_valid=0.
//  - TICK_DIV=4: mtime steps once per 4 clocks; assert rst low mid-read -> rd_valid and mtime drop to 0 at once.

Source files
------------

// File: rtl/ysyx_220066_clint_mh.sv
// rtl/ysyx_220066_clint_mh.sv - multi-hart CLINT on the data-memory path
// Shared prescaled mtime, per-hart mtimecmp/msip, registered read data and mtip.
module ysyx_220066_clint_mh #(
    parameter int          NHART        = 1,
    parameter logic [63:0] BASE         = 64'h2000000,
    parameter int          TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'h100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      addr,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic [63:0]      data,
    input  logic [7:0]       wstrb,
    output logic             MemRd_real,
    output logic             MemWr_real,
    output logic [63:0]      data_rd,
    output logic             rd_valid,
    output logic             error,
    output logic [NHART-1:0] msip,
    output logic [NHART-1:0] mtip
);

    localparam logic [63:0] LIMIT     = BASE + 64'hC000;
    localparam logic [4:0]  NH        = 5'(NHART);
    localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp [NHART];
    logic [NHART-1:0] msip_q;
    logic [PW-1:0]    presc;

    logic        hit;
    logic [15:0] off;
    logic        sel_msip;
    logic        sel_cmp;
    logic        sel_mtime;
    logic        tick;
    logic        msip_lane;
    logic        msip_bit;
    logic [63:0] rd_val;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  be);
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign hit        = (addr >= BASE) && (addr < LIMIT);
    assign off        = addr[15:0] - BASE[15:0];
    assign MemRd_real = MemRd && !hit;
    assign MemWr_real = MemWr && !hit;

    // Slot index must be below NHART; the index width is fixed at 4 bits (16 harts max).
    assign sel_msip  = hit && (off[15:6] == 10'd0) && (addr[1:0] == 2'b00)
                       && ({1'b0, off[5:2]} < NH);
    assign sel_cmp   = hit && (off[15:7] == 9'h080) && (addr[2:0] == 3'b000)
                       && ({1'b0, off[6:3]} < NH);
    assign sel_mtime = hit && (off == 16'hBFF8) && (addr[2:0] == 3'b000);

    assign tick      = (presc == PRESC_MAX);
    assign msip_lane = addr[2] ? wstrb[4] : wstrb[0];
    assign msip_bit  = addr[2] ? data[32] : data[0];
    assign msip      = msip_q;

    always_comb begin
        rd_val = '0;
        for (int h = 0; h < NHART; h++) begin
            if (sel_msip && off[5:2] == 4'(h))
                rd_val = addr[2] ? {31'd0, msip_q[h], 32'd0} : {63'd0, msip_q[h]};
            if (sel_cmp && off[6:3] == 4'(h))
                rd_val = mtimecmp[h];
        end
        if (sel_mtime) rd_val = mtime;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime    <= '0;
            presc    <= '0;
            msip_q   <= '0;
            mtip     <= '0;
            data_rd  <= '0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
            for (int h = 0; h < NHART; h++) mtimecmp[h] <= MTIMECMP_RST;
        end else begin
            rd_valid <= MemRd && hit;
            if (MemRd && hit) data_rd <= rd_val;
            error <= (MemRd || MemWr) && hit && !(sel_msip || sel_cmp || sel_mtime);

            // A software write to mtime overrides the tick and restarts the prescaler.
            if (MemWr && sel_mtime) begin
                mtime <= byte_merge(mtime, data, wstrb);
                presc <= '0;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            for (int h = 0; h < NHART; h++) begin
                mtip[h] <= (mtime >= mtimecmp[h]);
                if (MemWr && sel_cmp && off[6:3] == 4'(h))
                    mtimecmp[h] <= byte_merge(mtimecmp[h], data, wstrb);
                if (MemWr && sel_msip && off[5:2] == 4'(h) && msip_lane)
                    msip_q[h] <= msip_bit;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_clint_mh.sv
// tb/tb_ysyx_220066_clint_mh.sv - randomized self-checking bench for ysyx_220066_clint_mh
// Two instances: a 2-hart unit with TICK_DIV=1 against a behavioural model, and a TICK_DIV=4 unit.
module tb_ysyx_220066_clint_mh;

    localparam logic [63:0] BASE  = 64'h2000000;
    localparam int          NH    = 2;
    localparam int          TICKA = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rd, wr;
    logic [63:0] addr, data;
    logic [7:0]  wstrb;
    logic        rd_real, wr_real, rd_valid, error;
    logic [63:0] data_rd;
    logic [NH-1:0] msip, mtip;

    logic        rst_b, rd_b, wr_b;
    logic [63:0] addr_b, data_b;
    logic [7:0]  wstrb_b;
    logic        rd_real_b, wr_real_b, rd_valid_b, error_b;
    logic [63:0] data_rd_b;
    logic [0:0]  msip_b, mtip_b;

    ysyx_220066_clint_mh #(.NHART(NH), .BASE(BASE), .TICK_DIV(TICKA), .MTIMECMP_RST(64'h100)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .MemRd(rd), .MemWr(wr), .data(data), .wstrb(wstrb),
        .MemRd_real(rd_real), .MemWr_real(wr_real), .data_rd(data_rd), .rd_valid(rd_valid),
        .error(error), .msip(msip), .mtip(mtip));

    ysyx_220066_clint_mh #(.NHART(1), .BASE(BASE), .TICK_DIV(4), .MTIMECMP_RST(64'h100)) u_dut_div (
        .clk(clk), .rst(rst_b), .addr(addr_b), .MemRd(rd_b), .MemWr(wr_b), .data(data_b), .wstrb(wstrb_b),
        .MemRd_real(rd_real_b), .MemWr_real(wr_real_b), .data_rd(data_rd_b), .rd_valid(rd_valid_b),
        .error(error_b), .msip(msip_b), .mtip(mtip_b));

    int checks = 0;
    int errors = 0;

    // Reference state of the 2-hart unit.
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    int            m_presc;
    logic [63:0]   e_data;

    // -1 outside the window, 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime.
    function automatic int slot_kind(input logic [63:0] a, output int h);
        logic [63:0] o;
        h = 0;
        if (a < BASE || a >= BASE + 64'hC000) return -1;
        o = a - BASE;
        if (o < 4 * NH && o % 4 == 0) begin h = int'(o / 4); return 1; end
        if (o >= 64'h4000 && o < 64'h4000 + 8 * NH && o % 8 == 0) begin
            h = int'((o - 64'h4000) / 8);
            return 2;
        end
        if (o == 64'hBFF8) return 3;
        return 0;
    endfunction

    function automatic logic [63:0] masked(input logic [63:0] old_v, input logic [63:0] new_v,
                                           input logic [7:0] be);
        logic [63:0] mask = 0;
        for (int i = 0; i < 8; i++) if (be[i]) mask = mask | (64'hFF << (8 * i));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic step(input logic r, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] s);
        int k, h, lane;
        logic          e_valid, e_err;
        logic [NH-1:0] e_mtip;
        rd = r; wr = w; addr = a; data = d; wstrb = s;
        k = slot_kind(a, h);
        #1;
        checks++;
        if (rd_real !== (r && k < 0) || wr_real !== (w && k < 0)) begin
            errors++;
            $display("FAIL passthru addr=%h got rd/wr_real=%b%b want %b%b", a, rd_real, wr_real,
                     r && k < 0, w && k < 0);
        end
        for (int i = 0; i < NH; i++) e_mtip[i] = (m_mtime >= m_cmp[i]);
        e_valid = r && k >= 0;
        e_err   = (r || w) && k == 0;
        if (e_valid) begin
            case (k)
                1:       e_data = 64'(m_msip[h]) << (a[2] ? 32 : 0);
                2:       e_data = m_cmp[h];
                3:       e_data = m_mtime;
                default: e_data = 64'd0;
            endcase
        end
        if (w && k == 3) begin
            m_mtime = masked(m_mtime, d, s);
            m_presc = 0;
        end else begin
            m_presc++;
            if (m_presc == TICKA) begin m_mtime = m_mtime + 1; m_presc = 0; end
        end
        if (w && k == 2) m_cmp[h] = masked(m_cmp[h], d, s);
        lane = a[2] ? 4 : 0;
        if (w && k == 1 && s[lane]) m_msip[h] = d[lane * 8];
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== e_valid || data_rd !== e_data || error !== e_err
            || mtip !== e_mtip || msip !== m_msip) begin
            errors++;
            $display("FAIL model addr=%h r=%b w=%b got v=%b d=%h e=%b tip=%b sip=%b want v=%b d=%h e=%b tip=%b sip=%b",
                     a, r, w, rd_valid, data_rd, error, mtip, msip,
                     e_valid, e_data, e_err, e_mtip, m_msip);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0; rd = 0; wr = 0; addr = 0; data = 0; wstrb = 0;
        rst_b = 1'b0; rd_b = 0; wr_b = 0; addr_b = 0; data_b = 0; wstrb_b = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_rd !== 64'd0 || rd_valid !== 1'b0 || error !== 1'b0 || msip !== 2'b00 || mtip !== 2'b00) begin
            errors++;
            $display("FAIL reset got d=%h v=%b e=%b sip=%b tip=%b want all zero",
                     data_rd, rd_valid, error, msip, mtip);
        end
        m_mtime = 0; m_presc = 0; m_msip = 0; e_data = 0;
        for (int i = 0; i < NH; i++) m_cmp[i] = 64'h100;
        rst = 1'b1;
    endtask

    task automatic test_mtime_count();
        int n = 0;
        while (m_mtime != 64'h6 && n < 50) begin idle(); n++; end
        checks++;
        if (m_mtime != 64'h6) begin errors++; $display("FAIL count_wait got %h want 6", m_mtime); end
        step(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'd0);
        checks++;
        if (data_rd !== 64'h6) begin errors++; $display("FAIL mtime_at6 got %h want 6", data_rd); end
        repeat (9) idle();
        step(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'd0);
        checks++;
        if (data_rd !== 64'h10) begin errors++; $display("FAIL mtime_at10 got %h want 10", data_rd); end
    endtask

    task automatic test_mtimecmp();
        step(1'b0, 1'b1, BASE + 64'h4008, 64'h20, 8'hFF);
        while (m_mtime < 64'h40) begin
            idle();
            if (m_mtime >= 64'h21 && m_mtime <= 64'h100) begin
                checks++;
                if (mtip !== 2'b10) begin
                    errors++;
                    $display("FAIL mtip_split at %h got %b want 10", m_mtime, mtip);
                end
            end
        end
    endtask

    task automatic test_msip();
        step(1'b0, 1'b1, BASE + 64'h4, 64'h1_0000_0000, 8'hF0);
        checks++;
        if (msip !== 2'b10) begin errors++; $display("FAIL msip_set got %b want 10", msip); end
        step(1'b1, 1'b0, BASE + 64'h4, 64'd0, 8'd0);
        checks++;
        if (data_rd !== 64'h1_0000_0000 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL msip_read got %h v=%b want 100000000 v=1", data_rd, rd_valid);
        end
        step(1'b0, 1'b1, BASE, 64'h1, 8'h00);
        step(1'b0, 1'b1, BASE, 64'h1, 8'h01);
        checks++;
        if (msip !== 2'b11) begin errors++; $display("FAIL msip_lane0 got %b want 11", msip); end
        step(1'b0, 1'b1, BASE, 64'h0, 8'h0F);
    endtask

    task automatic test_mtip0();
        int n = 0;
        while (m_mtime != 64'h100 && n < 400) begin idle(); n++; end
        checks++;
        if (m_mtime != 64'h100 || mtip[0] !== 1'b0) begin
            errors++;
            $display("FAIL mtip0_before got %b at %h want 0 at 100", mtip[0], m_mtime);
        end
        idle();
        checks++;
        if (mtip[0] !== 1'b1) begin errors++; $display("FAIL mtip0_rise got %b want 1", mtip[0]); end
    endtask

    task automatic test_mtime_write();
        logic [31:0] hi;
        hi = m_mtime[63:32];
        step(1'b0, 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        step(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'd0);
        checks++;
        if (data_rd !== {hi, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL mtime_low got %h want %h", data_rd, {hi, 32'hFFFF_FFFF});
        end
        step(1'b0, 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'd0);
        checks++;
        if (data_rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL mtime_ones got %h want all ones", data_rd);
        end
        step(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'd0);
        checks++;
        if (data_rd !== 64'd0) begin errors++; $display("FAIL mtime_wrap got %h want 0", data_rd); end
    endtask

    task automatic test_unmapped();
        step(1'b1, 1'b0, BASE + 64'h4010, 64'd0, 8'd0);
        checks++;
        if (data_rd !== 64'd0 || error !== 1'b1) begin
            errors++;
            $display("FAIL unmapped got d=%h e=%b want 0 1", data_rd, error);
        end
        rd = 1'b1; wr = 1'b0; addr = 64'h8000_0000;
        #1;
        checks++;
        if (rd_real !== 1'b1) begin errors++; $display("FAIL mem_rd_real got %b want 1", rd_real); end
        step(1'b1, 1'b0, 64'h8000_0000, 64'd0, 8'd0);
        checks++;
        if (rd_valid !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL mem_pass got v=%b e=%b want 0 0", rd_valid, error);
        end
    endtask

    task automatic test_random();
        logic [63:0] slots [12];
        slots[0] = BASE;             slots[1] = BASE + 64'h4;      slots[2] = BASE + 64'h8;
        slots[3] = BASE + 64'h4000;  slots[4] = BASE + 64'h4008;   slots[5] = BASE + 64'h4010;
        slots[6] = BASE + 64'hBFF8;  slots[7] = BASE + 64'hBFF0;   slots[8] = BASE + 64'h2;
        slots[9] = BASE + 64'h4004;  slots[10] = 64'h8000_0000;    slots[11] = BASE + 64'hC000;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), slots[$urandom_range(0, 11)],
                 {$urandom, $urandom}, 8'($urandom));
        end
    endtask

    task automatic test_prescaler();
        rst_b = 1'b1;
        rd_b = 1'b1; addr_b = BASE + 64'hBFF8;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (data_rd_b !== 64'(i / 4) || rd_valid_b !== 1'b1) begin
                errors++;
                $display("FAIL div4 cycle %0d got %h v=%b want %h v=1", i, data_rd_b, rd_valid_b, i / 4);
            end
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (rd_valid_b !== 1'b0 || data_rd_b !== 64'd0) begin
            errors++;
            $display("FAIL midreset got v=%b d=%h want 0 0", rd_valid_b, data_rd_b);
        end
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (data_rd_b !== 64'd0 || rd_valid_b !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got %h v=%b want 0 v=1", data_rd_b, rd_valid_b);
        end
        rd_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mtime_count();
        test_mtimecmp();
        test_msip();
        test_mtip0();
        test_mtime_write();
        test_unmapped();
        test_random();
        test_prescaler();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
